legv8_bus_controller: RTL and testbench
=======================================

LEGV8_BUS_CONTROLLER -- requirements
Module: legv8_bus_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, CPU/device data width; legal values 32 or 64.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-003 SHALL have parameter NUM_REGIONS, default 2, number of decoded device regions, range 1..8.
REQ-004 SHALL have parameter REGION_BASE, default {32'h20000000, 32'h00000000}, packed NUM_REGIONS*ADDR_WIDTH bases; region 0 is in the LSBs.
REQ-005 SHALL have parameter REGION_MASK, default {32'hFFFFFF00, 32'hFFFFFC00}, packed match masks.
REQ-006 SHALL have parameter REGION_WAIT, default {4'd1, 4'd0}, packed 4-bit wait states per region.
REQ-007 SHALL have parameter REGION_RO, default 2'b10, read-only bitmask, one bit per region.
REQ-008 Ports: clock in 1, sole clock, rising edge; reset in 1, asynchronous, active-low.
REQ-009 Ports: req in 1 (access request pulse); we in 1 (1 = write); size in 2 (00 byte, 01 half, 10 word, 11 double); addr in ADDR_WIDTH; wdata in DATA_WIDTH.
REQ-010 Ports: ready out 1; rdata out DATA_WIDTH; fault out 1; fault_code out 2; busy out 1; drop_count out 8.
REQ-011 Ports: dev_sel out NUM_REGIONS (one-hot); dev_we out 1; dev_addr out ADDR_WIDTH; dev_wdata out DATA_WIDTH; dev_be out DATA_WIDTH/8; dev_rdata in NUM_REGIONS*DATA_WIDTH (region 0 in the LSBs).

Function
REQ-012 SHALL implement the FSM IDLE -> ACCESS -> RESP -> IDLE; any fault path goes IDLE -> RESP.
REQ-013 In IDLE, on req=1 at a clock edge, SHALL latch we/size/addr/wdata and decode: hit(i) = ((addr & MASK_i) == BASE_i); the lowest hit index wins on overlap.
REQ-014 Fault priority: unmapped (01) > misaligned (10; addr low bits nonzero for size, or size=11 with DATA_WIDTH=32) > write to RO region (11); fault_code=00 when there is no fault.
REQ-015 On fault, SHALL go to RESP with no dev_sel pulse; ready and fault are 1 one cycle after acceptance.
REQ-016 In ACCESS, SHALL hold dev_sel[i]=1, dev_we, dev_addr (aligned to DATA_WIDTH/8), dev_be and dev_wdata stable for exactly WAIT_i+1 cycles; dev_we SHALL be 0 outside ACCESS.
REQ-017 dev_be = (2^(2^size)-1) << addr[lane bits]; dev_wdata = wdata << (8*addr[lane bits]).
REQ-018 On the last ACCESS cycle, SHALL capture dev_rdata slice i, shift it right by 8*addr[lane bits] and zero-extend it above the access size into rdata.
REQ-019 RESP lasts one cycle with ready=1; total latency from acceptance to ready = WAIT_i+2 cycles on success and 1 cycle on fault.
REQ-020 rdata, fault and fault_code SHALL hold their values until the next RESP; rdata SHALL be 0 after writes and after faults.
REQ-021 busy = (state != IDLE); a req seen while busy SHALL be dropped and SHALL increment drop_count, which saturates at 255.
REQ-022 A req in the IDLE cycle directly following RESP SHALL be accepted (back-to-back).

Reset
REQ-023 With reset=0, SHALL asynchronously force state IDLE and ready, fault, busy, dev_sel, dev_we, dev_be to 0; fault_code, rdata, dev_addr, dev_wdata and drop_count to 0.
REQ-024 Reset mid-ACCESS SHALL drop dev_sel in the same cycle without generating ready; the first edge after reset=1 samples req normally.

Verification
REQ-025 Read double at 0x00000010, dev_rdata region0 = 64'h1122334455667788 -> dev_sel=01 for 1 cycle, ready 2 cycles after acceptance, rdata = 64'h1122334455667788.
REQ-026 Read byte at 0x20000003, region1 lane 3 = 8'hA5, WAIT=1 -> dev_sel=10 for 2 cycles, dev_be=8'h08, ready at cycle 3, rdata = 64'h00000000000000A5.
REQ-027 Write half 16'hBEEF at 0x00000006 -> dev_be=8'hC0, dev_wdata[63:48]=16'hBEEF, dev_we=1 for 1 cycle, fault=0.
REQ-028 Faults: addr 0x40000000 -> fault_code 01; word at 0x00000002 -> 10; write to 0x20000000 -> 11; each gives ready after 1 cycle, no dev_sel, rdata=0.
REQ-029 Three req pulses during one region1 access -> drop_count=3; 300 dropped pulses -> drop_count=255.
REQ-030 reset=0 asserted during the second ACCESS cycle of region1 -> dev_sel=0 immediately, no ready, all outputs at reset values; next req completes normally.

Source files
------------

// File: rtl/legv8_bus_controller.sv
// Single-master bus controller: decodes CPU accesses onto NUM_REGIONS memory-mapped devices
// with per-region wait states, byte lanes, read-only protection and fault reporting.
module legv8_bus_controller #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 32,
    parameter int NUM_REGIONS = 2,
    parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE = {32'h20000000, 32'h00000000},
    parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_MASK = {32'hFFFFFF00, 32'hFFFFFC00},
    parameter logic [NUM_REGIONS*4-1:0]          REGION_WAIT = {4'd1, 4'd0},
    parameter logic [NUM_REGIONS-1:0]            REGION_RO   = 2'b10
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              req,
    input  logic                              we,
    input  logic [1:0]                        size,
    input  logic [ADDR_WIDTH-1:0]             addr,
    input  logic [DATA_WIDTH-1:0]             wdata,
    output logic                              ready,
    output logic [DATA_WIDTH-1:0]             rdata,
    output logic                              fault,
    output logic [1:0]                        fault_code,
    output logic                              busy,
    output logic [7:0]                        drop_count,
    output logic [NUM_REGIONS-1:0]            dev_sel,
    output logic                              dev_we,
    output logic [ADDR_WIDTH-1:0]             dev_addr,
    output logic [DATA_WIDTH-1:0]             dev_wdata,
    output logic [DATA_WIDTH/8-1:0]           dev_be,
    input  logic [NUM_REGIONS*DATA_WIDTH-1:0] dev_rdata
);

    localparam int BE_W   = DATA_WIDTH / 8;
    localparam int LANE_W = $clog2(BE_W);
    localparam int IDX_W  = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    function automatic logic [BE_W-1:0] lane_enable(input logic [1:0] sz, input logic [LANE_W-1:0] lane);
        logic [15:0] ones;
        ones = (16'd1 << (5'd1 << sz)) - 16'd1;
        return BE_W'(ones << lane);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'd0:    return DATA_WIDTH'(8'hFF);
            2'd1:    return DATA_WIDTH'(16'hFFFF);
            2'd2:    return DATA_WIDTH'(32'hFFFF_FFFF);
            default: return '1;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] sz, input logic [LANE_W-1:0] lane);
        logic [LANE_W-1:0] low;
        low = LANE_W'((4'd1 << sz) - 4'd1);
        return ((lane & low) != '0) || ((sz == 2'd3) && (DATA_WIDTH == 32));
    endfunction

    state_t                  state_q, state_d;
    logic                    ready_q, ready_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    fault_q, fault_d;
    logic [1:0]              fault_code_q, fault_code_d;
    logic                    busy_q, busy_d;
    logic [7:0]              drop_count_q, drop_count_d;
    logic [NUM_REGIONS-1:0]  dev_sel_q, dev_sel_d;
    logic                    dev_we_q, dev_we_d;
    logic [ADDR_WIDTH-1:0]   dev_addr_q, dev_addr_d;
    logic [DATA_WIDTH-1:0]   dev_wdata_q, dev_wdata_d;
    logic [BE_W-1:0]         dev_be_q, dev_be_d;
    logic [3:0]              wait_cnt_q, wait_cnt_d;
    logic [1:0]              size_q, size_d;
    logic [LANE_W-1:0]       lane_q, lane_d;
    logic [IDX_W-1:0]        sel_idx_q, sel_idx_d;
    logic                    wr_q, wr_d;

    logic                    hit_any;
    logic [IDX_W-1:0]        hit_idx;
    logic [1:0]              req_code;
    logic [LANE_W-1:0]       req_lane;
    logic [DATA_WIDTH-1:0]   rd_slice;
    logic [DATA_WIDTH-1:0]   rd_value;

    // Descending scan so the lowest matching region index wins on overlap.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if ((addr & REGION_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    assign req_lane = addr[LANE_W-1:0];

    always_comb begin
        req_code = 2'b00;
        if (!hit_any)
            req_code = 2'b01;
        else if (misaligned(size, req_lane))
            req_code = 2'b10;
        else if (we && REGION_RO[hit_idx])
            req_code = 2'b11;
    end

    assign rd_slice = dev_rdata[int'(sel_idx_q)*DATA_WIDTH +: DATA_WIDTH];
    assign rd_value = (rd_slice >> {lane_q, 3'b000}) & size_mask(size_q);

    always_comb begin
        state_d      = state_q;
        ready_d      = 1'b0;
        rdata_d      = rdata_q;
        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        busy_d       = busy_q;
        drop_count_d = drop_count_q;
        dev_sel_d    = dev_sel_q;
        dev_we_d     = dev_we_q;
        dev_addr_d   = dev_addr_q;
        dev_wdata_d  = dev_wdata_q;
        dev_be_d     = dev_be_q;
        wait_cnt_d   = wait_cnt_q;
        size_d       = size_q;
        lane_d       = lane_q;
        sel_idx_d    = sel_idx_q;
        wr_d         = wr_q;

        if (req && (state_q != S_IDLE) && (drop_count_q != 8'hFF))
            drop_count_d = drop_count_q + 8'd1;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    busy_d = 1'b1;
                    if (req_code != 2'b00) begin
                        state_d      = S_RESP;
                        ready_d      = 1'b1;
                        fault_d      = 1'b1;
                        fault_code_d = req_code;
                        rdata_d      = '0;
                    end else begin
                        state_d     = S_ACCESS;
                        dev_sel_d   = NUM_REGIONS'(1) << hit_idx;
                        dev_we_d    = we;
                        dev_addr_d  = {addr[ADDR_WIDTH-1:LANE_W], LANE_W'(0)};
                        dev_be_d    = lane_enable(size, req_lane);
                        dev_wdata_d = wdata << {req_lane, 3'b000};
                        wait_cnt_d  = REGION_WAIT[int'(hit_idx)*4 +: 4];
                        size_d      = size;
                        lane_d      = req_lane;
                        sel_idx_d   = hit_idx;
                        wr_d        = we;
                    end
                end
            end
            S_ACCESS: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d      = S_RESP;
                    ready_d      = 1'b1;
                    fault_d      = 1'b0;
                    fault_code_d = 2'b00;
                    rdata_d      = wr_q ? '0 : rd_value;
                    dev_sel_d    = '0;
                    dev_we_d     = 1'b0;
                    dev_be_d     = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ready_q      <= 1'b0;
            rdata_q      <= '0;
            fault_q      <= 1'b0;
            fault_code_q <= 2'b00;
            busy_q       <= 1'b0;
            drop_count_q <= 8'd0;
            dev_sel_q    <= '0;
            dev_we_q     <= 1'b0;
            dev_addr_q   <= '0;
            dev_wdata_q  <= '0;
            dev_be_q     <= '0;
            wait_cnt_q   <= 4'd0;
            size_q       <= 2'd0;
            lane_q       <= '0;
            sel_idx_q    <= '0;
            wr_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            rdata_q      <= rdata_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
            busy_q       <= busy_d;
            drop_count_q <= drop_count_d;
            dev_sel_q    <= dev_sel_d;
            dev_we_q     <= dev_we_d;
            dev_addr_q   <= dev_addr_d;
            dev_wdata_q  <= dev_wdata_d;
            dev_be_q     <= dev_be_d;
            wait_cnt_q   <= wait_cnt_d;
            size_q       <= size_d;
            lane_q       <= lane_d;
            sel_idx_q    <= sel_idx_d;
            wr_q         <= wr_d;
        end
    end

    assign ready      = ready_q;
    assign rdata      = rdata_q;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;
    assign busy       = busy_q;
    assign drop_count = drop_count_q;
    assign dev_sel    = dev_sel_q;
    assign dev_we     = dev_we_q;
    assign dev_addr   = dev_addr_q;
    assign dev_wdata  = dev_wdata_q;
    assign dev_be     = dev_be_q;

endmodule

// File: tb/tb_legv8_bus_controller.sv
// Randomized bench for legv8_bus_controller against a transaction-level reference model.
module tb_legv8_bus_controller;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req = 1'b0;
    logic         we = 1'b0;
    logic [1:0]   size = 2'd0;
    logic [31:0]  addr = 32'd0;
    logic [63:0]  wdata = 64'd0;
    logic [127:0] dev_rdata = '0;

    logic         ready;
    logic [63:0]  rdata;
    logic         fault;
    logic [1:0]   fault_code;
    logic         busy;
    logic [7:0]   drop_count;
    logic [1:0]   dev_sel;
    logic         dev_we;
    logic [31:0]  dev_addr;
    logic [63:0]  dev_wdata;
    logic [7:0]   dev_be;

    int n_checks = 0;
    int n_fail   = 0;
    int drops_exp = 0;

    // Device map seen by the model: base, mask, wait states, read-only.
    logic [31:0] base_m [2] = '{32'h00000000, 32'h20000000};
    logic [31:0] mask_m [2] = '{32'hFFFFFC00, 32'hFFFFFF00};
    int          wait_m [2] = '{0, 1};
    bit          ro_m   [2] = '{1'b0, 1'b1};

    legv8_bus_controller dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .addr(addr), .wdata(wdata),
        .ready(ready), .rdata(rdata), .fault(fault), .fault_code(fault_code), .busy(busy),
        .drop_count(drop_count), .dev_sel(dev_sel), .dev_we(dev_we), .dev_addr(dev_addr),
        .dev_wdata(dev_wdata), .dev_be(dev_be), .dev_rdata(dev_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic note_drop;
        drops_exp = (drops_exp < 255) ? drops_exp + 1 : 255;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, 64'(ready), 64'd0);
        check({tag, "_rdata"}, rdata, 64'd0);
        check({tag, "_fault"}, 64'(fault), 64'd0);
        check({tag, "_code"}, 64'(fault_code), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_drops"}, 64'(drop_count), 64'd0);
        check({tag, "_sel"}, 64'(dev_sel), 64'd0);
        check({tag, "_we"}, 64'(dev_we), 64'd0);
        check({tag, "_be"}, 64'(dev_be), 64'd0);
        check({tag, "_daddr"}, 64'(dev_addr), 64'd0);
        check({tag, "_dwdata"}, dev_wdata, 64'd0);
    endtask

    // Reference: which region answers, and what fault (if any) the access raises.
    function automatic void model(input bit w, input logic [1:0] sz, input logic [31:0] a,
                                  output int region, output int code);
        region = -1;
        for (int i = 0; i < 2; i++)
            if (region < 0 && ((a & mask_m[i]) == base_m[i])) region = i;
        if (region < 0)                         code = 1;
        else if ((a % (32'd1 << sz)) != 0)      code = 2;
        else if (w && ro_m[region])             code = 3;
        else                                    code = 0;
    endfunction

    task automatic do_txn(input bit w, input logic [1:0] sz, input logic [31:0] a,
                          input logic [63:0] wd, input logic [127:0] rd, input int drop_pct);
        int region, code, lane, nwait;
        logic [7:0]  be_exp;
        logic [63:0] wd_exp, rd_exp, sl;
        model(w, sz, a, region, code);
        lane   = int'(a % 8);
        be_exp = 8'(((1 << (1 << sz)) - 1) << lane);
        wd_exp = wd << (8 * lane);
        rd_exp = 64'd0;
        if (code == 0 && !w) begin
            sl = rd[region*64 +: 64];
            rd_exp = sl >> (8 * lane);
            if (sz != 2'd3) rd_exp = rd_exp & ((64'd1 << (8 << sz)) - 64'd1);
        end
        dev_rdata = rd;
        we = w; size = sz; addr = a; wdata = wd; req = 1'b1;
        step;
        req = 1'b0;
        we = ~w; size = 2'($urandom); addr = $urandom; wdata = {$urandom, $urandom};
        if (code != 0) begin
            check("flt_ready", 64'(ready), 64'd1);
            check("flt_fault", 64'(fault), 64'd1);
            check("flt_code", 64'(fault_code), 64'(code));
            check("flt_sel", 64'(dev_sel), 64'd0);
            check("flt_rdata", rdata, 64'd0);
        end else begin
            nwait = wait_m[region];
            for (int k = 0; k <= nwait; k++) begin
                check("acc_sel", 64'(dev_sel), 64'(2'b01 << region));
                check("acc_we", 64'(dev_we), 64'(w));
                check("acc_be", 64'(dev_be), 64'(be_exp));
                check("acc_addr", 64'(dev_addr), 64'(a - (a % 8)));
                check("acc_wdata", dev_wdata, wd_exp);
                check("acc_ready", 64'(ready), 64'd0);
                req = ($urandom_range(99) < drop_pct);
                if (req) note_drop();
                step;
            end
            req = 1'b0;
            check("rsp_ready", 64'(ready), 64'd1);
            check("rsp_fault", 64'(fault), 64'd0);
            check("rsp_code", 64'(fault_code), 64'd0);
            check("rsp_rdata", rdata, rd_exp);
            check("rsp_sel", 64'(dev_sel), 64'd0);
            check("rsp_we", 64'(dev_we), 64'd0);
        end
        check("rsp_busy", 64'(busy), 64'd1);
        req = ($urandom_range(99) < drop_pct);
        if (req) note_drop();
        step;
        req = 1'b0;
        check("idle_ready", 64'(ready), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_fault_hold", 64'(fault), 64'(code != 0));
        check("idle_rdata_hold", rdata, rd_exp);
        check("drop_count", 64'(drop_count), 64'(drops_exp));
    endtask

    initial begin
        logic [127:0] rd;
        logic [31:0]  a;
        repeat (2) step;
        check_reset_vals("rst");
        rst_n = 1'b1;

        do_txn(1'b0, 2'd3, 32'h00000010, 64'd0, {64'd0, 64'h1122334455667788}, 0);
        check("dbl_rdata", rdata, 64'h1122334455667788);
        rd = {$urandom, $urandom, $urandom, $urandom};
        rd[64+24 +: 8] = 8'hA5;
        do_txn(1'b0, 2'd0, 32'h20000003, 64'd0, rd, 0);
        check("byte_rdata", rdata, 64'h00000000000000A5);
        do_txn(1'b1, 2'd1, 32'h00000006, 64'h000000000000BEEF, '0, 0);
        check("half_rdata_zero", rdata, 64'd0);
        do_txn(1'b0, 2'd2, 32'h40000000, 64'd0, '0, 0);
        do_txn(1'b0, 2'd2, 32'h00000002, 64'd0, '0, 0);
        do_txn(1'b1, 2'd2, 32'h20000000, 64'd5, '0, 0);

        do_txn(1'b0, 2'd0, 32'h20000001, 64'd0, '0, 100);
        check("three_drops", 64'(drop_count), 64'd3);

        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(2))
                0:       a = 32'($urandom_range(32'h3FF));
                1:       a = 32'h20000000 + 32'($urandom_range(255));
                default: a = $urandom | 32'h40000000;
            endcase
            do_txn(1'($urandom), 2'($urandom), a, {$urandom, $urandom},
                   {$urandom, $urandom, $urandom, $urandom}, 20);
        end

        for (int n = 0; n < 100; n++)
            do_txn(1'b0, 2'd2, 32'h20000010, 64'd0, {$urandom, $urandom, $urandom, $urandom}, 100);
        check("drop_saturate", 64'(drop_count), 64'd255);

        // Asynchronous reset in the second wait cycle of a region-1 read.
        addr = 32'h20000008; size = 2'd3; we = 1'b0; req = 1'b1;
        step;
        req = 1'b0;
        step;
        check("mid_sel", 64'(dev_sel), 64'd2);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        #3;
        rst_n = 1'b1;
        drops_exp = 0;
        step;
        check("post_rst_ready", 64'(ready), 64'd0);
        check("post_rst_busy", 64'(busy), 64'd0);
        do_txn(1'b0, 2'd3, 32'h20000008, 64'd0, {$urandom, $urandom, $urandom, $urandom}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
